// File: rtl/rv32i_types_pkg.sv
// Shared core types: hazard-controller FSM states, redirect causes, FU slot indices.
package rv32i_types_pkg;

    typedef enum logic [1:0] {IDLE, FLUSH, DRAIN, REDIRECT} hazard_state_t;

    typedef enum logic [1:0] {CAUSE_NONE, CAUSE_EXC, CAUSE_INTR, CAUSE_IFENCE} redirect_cause_t;

    localparam int FU_AU = 0;
    localparam int FU_MU = 1;
    localparam int FU_DU = 2;
    localparam int FU_LS = 3;

endpackage

// File: rtl/ooo_scoreboard.sv
// Per-register busy/tag scoreboard with tag-matched writeback clear; OOO_HAZARD_WB_BYPASS_EN masks lookups.
// Latency: set/clear visible next cycle (same cycle for lookups when bypass is built in).
// Backpressure: none; the top gates the set strobe with its dispatch decision.
module ooo_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int NUM_WB   = 2,
    parameter int TAG_W    = 4,
    parameter int RW       = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_clr,
    input  logic                    set_vld,
    input  logic [RW-1:0]           set_rd,
    input  logic [TAG_W-1:0]        set_tag,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [NUM_WB*RW-1:0]    wb_rd,
    input  logic [NUM_WB*TAG_W-1:0] wb_tag,
    input  logic [RW-1:0]           rs1,
    input  logic [RW-1:0]           rs2,
    input  logic [RW-1:0]           rd,
    output logic                    rs1_hit,
    output logic                    rs2_hit,
    output logic                    rd_hit
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] wb_clr;
    logic [NUM_REGS-1:0] look_busy;
    logic [TAG_W-1:0]    tag [NUM_REGS];

    // Stale tags (register re-allocated since) must not clear the newer owner.
    always_comb begin
        wb_clr = '0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_valid[i] && busy[wb_rd[i*RW +: RW]] &&
                tag[wb_rd[i*RW +: RW]] == wb_tag[i*TAG_W +: TAG_W]) begin
                wb_clr[wb_rd[i*RW +: RW]] = 1'b1;
            end
        end
    end

`ifdef OOO_HAZARD_WB_BYPASS_EN
    assign look_busy = busy & ~wb_clr;
`else
    assign look_busy = busy;
`endif

    assign rs1_hit = look_busy[rs1];
    assign rs2_hit = look_busy[rs2];
    assign rd_hit  = look_busy[rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            for (int r = 0; r < NUM_REGS; r++) tag[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (flush_clr) begin
                    busy[r] <= 1'b0;
                end else if (set_vld && set_rd == RW'(r)) begin
                    busy[r] <= 1'b1;
                    tag[r]  <= set_tag;
                end else if (wb_clr[r]) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ooo_hazard_ctrl.sv
// Hazard/scoreboard controller: operand/WAW/FU stalls plus flush-drain-redirect sequencing (OOO_HAZARD_WB_BYPASS_EN adds wb bypass).
// Latency: stalls and dispatch_fire are combinational; flush asserted the cycle after the cause.
// Backpressure: stall_decode holds decode; pc_en drops while draining; watchdog forces redirect.
module ooo_hazard_ctrl
    import rv32i_types_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int NUM_FU    = 4,
    parameter int NUM_WB    = 2,
    parameter int TAG_W     = 4,
    parameter int DRAIN_MAX = 64
) (
    input  logic                                 CLK,
    input  logic                                 nRST,
    input  logic                                 dispatch_req,
    input  logic [$clog2(NUM_REGS)-1:0]          dispatch_rs1,
    input  logic [$clog2(NUM_REGS)-1:0]          dispatch_rs2,
    input  logic [$clog2(NUM_REGS)-1:0]          dispatch_rd,
    input  logic                                 rs1_used,
    input  logic                                 rs2_used,
    input  logic                                 dispatch_wen,
    input  logic [$clog2(NUM_FU)-1:0]            dispatch_fu,
    input  logic [TAG_W-1:0]                     dispatch_tag,
    input  logic [NUM_FU-1:0]                    fu_busy,
    input  logic                                 rob_full,
    input  logic                                 rob_empty,
    input  logic [NUM_WB-1:0]                    wb_valid,
    input  logic [NUM_WB*$clog2(NUM_REGS)-1:0]   wb_rd,
    input  logic [NUM_WB*TAG_W-1:0]              wb_tag,
    input  logic                                 mispredict,
    input  logic                                 exception,
    input  logic                                 intr,
    input  logic                                 ifence,
    input  logic                                 d_mem_busy,
    output logic                                 dispatch_fire,
    output logic                                 stall_decode,
    output logic [NUM_FU-1:0]                    stall_fu,
    output logic                                 rs1_busy,
    output logic                                 rs2_busy,
    output logic                                 pc_en,
    output logic                                 fetch_decode_flush,
    output logic                                 decode_execute_flush,
    output logic                                 execute_commit_flush,
    output logic                                 npc_sel,
    output logic                                 insert_priv_pc,
    output logic                                 drain_timeout
);

    localparam int RW = $clog2(NUM_REGS);
    localparam int CW = $clog2(DRAIN_MAX + 1);

    hazard_state_t   state, state_nxt;
    redirect_cause_t cause, cause_nxt;
    logic [CW-1:0]   drain_cnt;
    logic            rs1_hit, rs2_hit, rd_hit, waw;
    logic            drain_done, drain_hit;

    ooo_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WB   (NUM_WB),
        .TAG_W    (TAG_W),
        .RW       (RW)
    ) u_sb (
        .clk       (CLK),
        .rst_n     (nRST),
        .flush_clr (state == FLUSH),
        .set_vld   (dispatch_fire && dispatch_wen && dispatch_rd != '0),
        .set_rd    (dispatch_rd),
        .set_tag   (dispatch_tag),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_tag    (wb_tag),
        .rs1       (dispatch_rs1),
        .rs2       (dispatch_rs2),
        .rd        (dispatch_rd),
        .rs1_hit   (rs1_hit),
        .rs2_hit   (rs2_hit),
        .rd_hit    (rd_hit)
    );

    assign rs1_busy      = rs1_used && dispatch_rs1 != '0 && rs1_hit;
    assign rs2_busy      = rs2_used && dispatch_rs2 != '0 && rs2_hit;
    assign waw           = dispatch_wen && rd_hit;
    assign stall_decode  = state != IDLE || rob_full || rs1_busy || rs2_busy || waw ||
                           fu_busy[dispatch_fu];
    assign dispatch_fire = dispatch_req && !stall_decode;
    assign stall_fu      = fu_busy | {NUM_FU{state == FLUSH}};

    // A clean drain in the last allowed cycle is not a timeout.
    assign drain_done = rob_empty && !d_mem_busy;
    assign drain_hit  = !drain_done && drain_cnt == CW'(DRAIN_MAX - 1);

    always_comb begin
        state_nxt            = state;
        cause_nxt            = cause;
        pc_en                = 1'b1;
        fetch_decode_flush   = 1'b0;
        decode_execute_flush = 1'b0;
        execute_commit_flush = 1'b0;
        npc_sel              = 1'b0;
        insert_priv_pc       = 1'b0;
        case (state)
            IDLE: begin
                if (exception) begin
                    state_nxt = FLUSH;
                    cause_nxt = CAUSE_EXC;
                end else if (intr) begin
                    state_nxt = FLUSH;
                    cause_nxt = CAUSE_INTR;
                end else if (ifence) begin
                    state_nxt = FLUSH;
                    cause_nxt = CAUSE_IFENCE;
                end else if (mispredict) begin
                    state_nxt = FLUSH;
                    cause_nxt = CAUSE_NONE;
                end
            end
            FLUSH: begin
                fetch_decode_flush   = 1'b1;
                decode_execute_flush = 1'b1;
                execute_commit_flush = cause != CAUSE_NONE;
                npc_sel              = cause == CAUSE_NONE;
                state_nxt            = (cause == CAUSE_NONE) ? IDLE : DRAIN;
            end
            DRAIN: begin
                pc_en = 1'b0;
                if (drain_done || drain_hit) state_nxt = REDIRECT;
            end
            REDIRECT: begin
                insert_priv_pc = cause == CAUSE_EXC || cause == CAUSE_INTR;
                npc_sel        = cause == CAUSE_IFENCE;
                state_nxt      = IDLE;
                cause_nxt      = CAUSE_NONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= IDLE;
            cause         <= CAUSE_NONE;
            drain_cnt     <= '0;
            drain_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            cause <= cause_nxt;
            if (state == DRAIN && state_nxt == DRAIN) drain_cnt <= drain_cnt + 1'b1;
            else                                      drain_cnt <= '0;
            if (state == DRAIN && drain_hit) drain_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ooo_hazard_ctrl.sv
// Randomized + directed bench for ooo_hazard_ctrl against a behavioural scoreboard/redirect model.
module tb_ooo_hazard_ctrl;

    localparam int NR = 32, NF = 4, NW = 2, TW = 4, DMAX = 64, RW = 5;
`ifdef OOO_HAZARD_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam int M_IDLE = 0, M_FLUSH = 1, M_DRAIN = 2, M_REDIR = 3;
    localparam int C_NONE = 0, C_EXC = 1, C_INTR = 2, C_IFENCE = 3;

    logic CLK = 1'b0, nRST = 1'b0;
    logic dispatch_req, rs1_used, rs2_used, dispatch_wen;
    logic [RW-1:0] dispatch_rs1, dispatch_rs2, dispatch_rd;
    logic [1:0] dispatch_fu;
    logic [TW-1:0] dispatch_tag;
    logic [NF-1:0] fu_busy;
    logic rob_full, rob_empty, mispredict, exception, intr, ifence, d_mem_busy;
    logic [NW-1:0] wb_valid;
    logic [NW*RW-1:0] wb_rd;
    logic [NW*TW-1:0] wb_tag;
    logic dispatch_fire, stall_decode, rs1_busy, rs2_busy, pc_en;
    logic fetch_decode_flush, decode_execute_flush, execute_commit_flush;
    logic npc_sel, insert_priv_pc, drain_timeout;
    logic [NF-1:0] stall_fu;

    ooo_hazard_ctrl #(.NUM_REGS(NR), .NUM_FU(NF), .NUM_WB(NW), .TAG_W(TW), .DRAIN_MAX(DMAX)) dut (
        .CLK(CLK), .nRST(nRST), .dispatch_req(dispatch_req),
        .dispatch_rs1(dispatch_rs1), .dispatch_rs2(dispatch_rs2), .dispatch_rd(dispatch_rd),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .dispatch_wen(dispatch_wen),
        .dispatch_fu(dispatch_fu), .dispatch_tag(dispatch_tag), .fu_busy(fu_busy),
        .rob_full(rob_full), .rob_empty(rob_empty), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_tag(wb_tag), .mispredict(mispredict), .exception(exception), .intr(intr),
        .ifence(ifence), .d_mem_busy(d_mem_busy), .dispatch_fire(dispatch_fire),
        .stall_decode(stall_decode), .stall_fu(stall_fu), .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy), .pc_en(pc_en), .fetch_decode_flush(fetch_decode_flush),
        .decode_execute_flush(decode_execute_flush), .execute_commit_flush(execute_commit_flush),
        .npc_sel(npc_sel), .insert_priv_pc(insert_priv_pc), .drain_timeout(drain_timeout)
    );

    always #5 CLK = ~CLK;

    int n_total = 0, n_bad = 0;

    // Reference model: register ownership and redirect sequence.
    bit m_busy [NR];
    int m_tag  [NR];
    int m_mode, m_cause, m_drain_n;
    bit m_timeout;
    bit e_fire;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int r = 0; r < NR; r++) begin
            m_busy[r] = 0;
            m_tag[r]  = 0;
        end
        m_mode = M_IDLE; m_cause = C_NONE; m_drain_n = 0; m_timeout = 0;
    endtask

    function automatic bit wb_match(input int r);
        for (int i = 0; i < NW; i++)
            if (wb_valid[i] && int'(wb_rd[i*RW +: RW]) == r && m_busy[r] &&
                m_tag[r] == int'(wb_tag[i*TW +: TW])) return 1;
        return 0;
    endfunction

    function automatic bit owned(input int r);
        return m_busy[r] && !(BYPASS && wb_match(r));
    endfunction

    task automatic check_outputs();
        bit r1, r2, waw, stl;
        r1  = rs1_used && dispatch_rs1 != 0 && owned(int'(dispatch_rs1));
        r2  = rs2_used && dispatch_rs2 != 0 && owned(int'(dispatch_rs2));
        waw = dispatch_wen && owned(int'(dispatch_rd));
        stl = m_mode != M_IDLE || rob_full || r1 || r2 || waw || fu_busy[dispatch_fu];
        e_fire = dispatch_req && !stl;
        chk("rs1_busy", 32'(rs1_busy), 32'(r1));
        chk("rs2_busy", 32'(rs2_busy), 32'(r2));
        chk("stall_decode", 32'(stall_decode), 32'(stl));
        chk("dispatch_fire", 32'(dispatch_fire), 32'(e_fire));
        chk("stall_fu", 32'(stall_fu), 32'(fu_busy | ((m_mode == M_FLUSH) ? 4'hF : 4'h0)));
        chk("pc_en", 32'(pc_en), 32'(m_mode != M_DRAIN));
        chk("fd_flush", 32'(fetch_decode_flush), 32'(m_mode == M_FLUSH));
        chk("de_flush", 32'(decode_execute_flush), 32'(m_mode == M_FLUSH));
        chk("ec_flush", 32'(execute_commit_flush), 32'(m_mode == M_FLUSH && m_cause != C_NONE));
        chk("npc_sel", 32'(npc_sel), 32'((m_mode == M_FLUSH && m_cause == C_NONE) ||
                                         (m_mode == M_REDIR && m_cause == C_IFENCE)));
        chk("insert_priv_pc", 32'(insert_priv_pc),
            32'(m_mode == M_REDIR && (m_cause == C_EXC || m_cause == C_INTR)));
        chk("drain_timeout", 32'(drain_timeout), 32'(m_timeout));
    endtask

    task automatic m_clock();
        bit clr [NR];
        for (int r = 0; r < NR; r++) clr[r] = wb_match(r);
        for (int r = 0; r < NR; r++) if (clr[r]) m_busy[r] = 0;
        if (e_fire && dispatch_wen && dispatch_rd != 0) begin
            m_busy[dispatch_rd] = 1;
            m_tag[dispatch_rd]  = int'(dispatch_tag);
        end
        case (m_mode)
            M_IDLE: begin
                if (exception)       begin m_mode = M_FLUSH; m_cause = C_EXC;    end
                else if (intr)       begin m_mode = M_FLUSH; m_cause = C_INTR;   end
                else if (ifence)     begin m_mode = M_FLUSH; m_cause = C_IFENCE; end
                else if (mispredict) begin m_mode = M_FLUSH; m_cause = C_NONE;   end
            end
            M_FLUSH: begin
                for (int r = 0; r < NR; r++) m_busy[r] = 0;
                m_mode = (m_cause == C_NONE) ? M_IDLE : M_DRAIN;
                m_drain_n = 0;
            end
            M_DRAIN: begin
                m_drain_n++;
                if (rob_empty && !d_mem_busy) m_mode = M_REDIR;
                else if (m_drain_n == DMAX) begin m_timeout = 1; m_mode = M_REDIR; end
            end
            default: begin m_mode = M_IDLE; m_cause = C_NONE; end
        endcase
    endtask

    task automatic step();
        #1 check_outputs();
        @(posedge CLK);
        m_clock();
        @(negedge CLK);
    endtask

    task automatic clear_in();
        dispatch_req = 0; rs1_used = 0; rs2_used = 0; dispatch_wen = 0;
        dispatch_rs1 = 0; dispatch_rs2 = 0; dispatch_rd = 0; dispatch_fu = 0; dispatch_tag = 0;
        fu_busy = 0; rob_full = 0; rob_empty = 1; wb_valid = 0; wb_rd = 0; wb_tag = 0;
        mispredict = 0; exception = 0; intr = 0; ifence = 0; d_mem_busy = 0;
    endtask

    task automatic set_wb0(input int rd, input int tg);
        wb_valid[0] = 1; wb_rd[RW-1:0] = RW'(rd); wb_tag[TW-1:0] = TW'(tg);
    endtask

    task automatic rand_in();
        int r;
        dispatch_req = 1'($urandom_range(0, 3) != 0);
        rs1_used = 1'($urandom); rs2_used = 1'($urandom); dispatch_wen = 1'($urandom);
        dispatch_rs1 = RW'($urandom_range(0, 7)); dispatch_rs2 = RW'($urandom_range(0, 7));
        dispatch_rd = RW'($urandom_range(0, 7)); dispatch_fu = 2'($urandom);
        dispatch_tag = TW'($urandom);
        fu_busy = 4'($urandom & $urandom);
        rob_full = 1'($urandom_range(0, 7) == 0);
        rob_empty = 1'($urandom_range(0, 3) == 0);
        d_mem_busy = 1'($urandom_range(0, 3) == 0);
        for (int i = 0; i < NW; i++) begin
            r = $urandom_range(0, 7);
            wb_valid[i] = 1'($urandom_range(0, 2) != 0);
            wb_rd[i*RW +: RW] = RW'(r);
            wb_tag[i*TW +: TW] = TW'($urandom_range(0, 1) ? m_tag[r] : int'($urandom));
        end
        mispredict = 1'($urandom_range(0, 29) == 0);
        exception = 1'($urandom_range(0, 79) == 0);
        intr = 1'($urandom_range(0, 79) == 0);
        ifence = 1'($urandom_range(0, 79) == 0);
    endtask

    initial begin
        clear_in();
        m_reset();
        #12 check_outputs();
        @(negedge CLK); nRST = 1;

        // RAW on x5, released by its writeback.
        dispatch_req = 1; dispatch_wen = 1; dispatch_rd = 5; dispatch_tag = 3; step();
        clear_in(); dispatch_req = 1; rs1_used = 1; dispatch_rs1 = 5; step();
        set_wb0(5, 3); step();
        clear_in(); rs1_used = 1; dispatch_rs1 = 5; step();
        // Stale-tag writeback must not clear the newer owner.
        dispatch_req = 1; dispatch_wen = 1; dispatch_rd = 5; dispatch_tag = 3; step();
        clear_in(); set_wb0(5, 3); step();
        clear_in(); dispatch_req = 1; dispatch_wen = 1; dispatch_rd = 5; dispatch_tag = 7; step();
        clear_in(); rs1_used = 1; dispatch_rs1 = 5; set_wb0(5, 3); step();
        wb_valid = 0; step();
        set_wb0(5, 7); wb_valid[1] = 1; wb_rd[2*RW-1:RW] = 5; wb_tag[2*TW-1:TW] = 7; step();
        clear_in(); rs1_used = 1; dispatch_rs1 = 5; step();
        // Mispredict flush, then exception racing a mispredict.
        dispatch_req = 1; dispatch_wen = 1; dispatch_rd = 9; dispatch_tag = 1; step();
        clear_in(); mispredict = 1; step();
        clear_in(); step(); rs2_used = 1; dispatch_rs2 = 9; step();
        clear_in(); exception = 1; mispredict = 1; rob_empty = 0; step();
        clear_in(); rob_empty = 0; for (int i = 0; i < 6; i++) step();
        rob_empty = 1; for (int i = 0; i < 3; i++) step();

        for (int c = 0; c < 3000; c++) begin rand_in(); step(); end

        clear_in(); for (int i = 0; i < 80 && m_mode != M_IDLE; i++) step();
        intr = 1; rob_empty = 0; step();
        clear_in(); rob_empty = 0; for (int i = 0; i < DMAX + 4; i++) step();
        clear_in(); for (int c = 0; c < 200; c++) begin rand_in(); step(); end

        // Async reset in the middle of a drain.
        clear_in(); for (int i = 0; i < 80 && m_mode != M_IDLE; i++) step();
        dispatch_req = 1; dispatch_wen = 1; dispatch_rd = 3; dispatch_tag = 2; step();
        clear_in(); ifence = 1; rob_empty = 0; step();
        clear_in(); rob_empty = 0; for (int i = 0; i < 4; i++) step();
        clear_in(); nRST = 0;
        #1 m_reset(); check_outputs();
        @(negedge CLK); nRST = 1;
        rs1_used = 1; dispatch_rs1 = 3; step();
        for (int c = 0; c < 300; c++) begin rand_in(); step(); end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ooo_hazard_ctrl.md
Name: ooo_hazard_ctrl

Overview:
Parametrised hazard/scoreboard controller for the out-of-order core, successor to the fixed single-issue hazard interface.
- Tracks per-architectural-register busy state with ROB tags across NUM_WB writeback ports.
- Generates decode-stall and per-FU stall, and sequences flush/redirect for mispredicts, exceptions, interrupts and ifence.
- Sits between decode/dispatch, the FU array, the ROB (cb) and fetch.

Parameters:
NUM_REGS, 32, architectural registers tracked (x0 never busy)
NUM_FU, 4, functional units (AU, MU, DU, LS order)
NUM_WB, 2, writeback/completion ports clearing busy bits
TAG_W, 4, ROB tag width
DRAIN_MAX, 64, drain-cycle watchdog limit before forced redirect

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
dispatch_req  in  1  decode presents an instruction
dispatch_rs1, dispatch_rs2, dispatch_rd  in  $clog2(NUM_REGS) each  register indices
rs1_used, rs2_used, dispatch_wen  in  1 each  operand-use / rd-write flags
dispatch_fu  in  $clog2(NUM_FU)  target FU
dispatch_tag  in  TAG_W  ROB tag allocated to the instruction
fu_busy  in  NUM_FU  per-FU busy
rob_full, rob_empty  in  1  ROB status
wb_valid  in  NUM_WB  completion valid
wb_rd  in  NUM_WB*$clog2(NUM_REGS)  completing rd
wb_tag  in  NUM_WB*TAG_W  completing tag
mispredict  in  1  branch resolved wrong (execute)
exception, intr, ifence  in  1  commit-stage redirect causes
d_mem_busy  in  1  data memory outstanding
dispatch_fire  out  1  instruction dispatched this cycle
stall_decode  out  1  hold decode
stall_fu  out  NUM_FU  per-FU issue stall
rs1_busy, rs2_busy  out  1  operand hazard flags
pc_en  out  1  fetch PC advance enable
fetch_decode_flush, decode_execute_flush, execute_commit_flush  out  1  stage flushes
npc_sel  out  1  select branch/jump target
insert_priv_pc  out  1  select privileged vector
drain_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (nRST low, async): all busy bits 0, tags 0, FSM IDLE, drain counter 0; all outputs 0 except pc_en=1.
- Scoreboard: busy[r], tag[r] per register. On dispatch_fire && dispatch_wen && rd!=0: busy[rd]<=1, tag[rd]<=dispatch_tag.
- Writeback port i: clears busy[wb_rd] only if busy and tag[wb_rd]==wb_tag; stale tags ignored. Two ports, same rd, matching tag: cleared once, no error.
- Same-cycle dispatch and matching wb on same rd: dispatch set wins (new tag).
- rs1_busy = rs1_used && rs1!=0 && busy[rs1]; same for rs2. rd WAW hazard = dispatch_wen && busy[rd].
- stall_decode = state!=IDLE || rob_full || rs1_busy || rs2_busy || WAW || fu_busy[dispatch_fu].
- dispatch_fire = dispatch_req && !stall_decode. Combinational; scoreboard update takes effect next cycle.
- stall_fu[k] = fu_busy[k] || state==FLUSH.
- FSM states: IDLE, FLUSH, DRAIN, REDIRECT.
  - IDLE, mispredict: go to FLUSH. Assert fetch_decode_flush, decode_execute_flush and npc_sel for exactly 1 cycle; clear all busy bits whose tag is not yet committed (whole scoreboard clear); return to IDLE next cycle.
  - IDLE, exception|intr|ifence: go to FLUSH and assert all three flushes for 1 cycle, then DRAIN.
  - Priority: exception > intr > ifence > mispredict. A mispredict coincident with a commit cause is discarded.
  - DRAIN: pc_en=0. Hold until rob_empty && !d_mem_busy, or until the counter reaches DRAIN_MAX, which sets drain_timeout (sticky until reset). Then go to REDIRECT.
  - REDIRECT: 1 cycle. insert_priv_pc=1 for exception/intr; for ifence, npc_sel=1 (ifence_pc). pc_en=1. Return to IDLE.
- Causes arriving while not IDLE are ignored; their stages are already being flushed.
- Reset mid-FSM: immediate return to IDLE, scoreboard cleared.

Optional Feature:
OOO_HAZARD_WB_BYPASS_EN
- Defined: a matching writeback in the current cycle masks rs1_busy, rs2_busy and WAW combinationally, so dependents dispatch in the same cycle as writeback.
- Undefined: busy clears only at the clock edge, giving a 1-cycle extra stall.

Decomposition:
- rv32i_types_pkg gains:
  - hazard_state_t enum {IDLE, FLUSH, DRAIN, REDIRECT}
  - redirect_cause_t enum {CAUSE_NONE, CAUSE_EXC, CAUSE_INTR, CAUSE_IFENCE}
  - localparams for FU indices.
- One sub-module, ooo_scoreboard: busy/tag arrays, wb clear logic, rs/rd lookup, bypass macro. The top module holds the FSM, stalls and the watchdog.

Test Plan:
- Dispatch rd=5 tag=3, next cycle rs1=5 → rs1_busy=1, stall_decode=1; wb rd=5 tag=3 → stall drops the next cycle, or the same cycle with OOO_HAZARD_WB_BYPASS_EN.
- Dispatch rd=5 tag=3, then rd=5 tag=7 (after WAW clear), then wb rd=5 tag=3 → busy[5] stays 1; wb tag=7 clears it.
- mispredict in IDLE → one cycle of fetch_decode_flush=decode_execute_flush=npc_sel=1, scoreboard all 0, IDLE next.
- exception with rob_empty=0 for 5 cycles → FLUSH 1 cycle, DRAIN 5 cycles with pc_en=0, REDIRECT with insert_priv_pc=1 for 1 cycle.
- exception and mispredict in the same cycle → exception path only; npc_sel stays 0 in the FLUSH cycle.
- rob_empty held 0 for DRAIN_MAX=64 → drain_timeout=1 at cycle 64, REDIRECT; nRST pulsed mid-DRAIN → IDLE and all outputs at reset values.
